// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction buffer between fetch and decode. Holds up to DEPTH entries of
// {instr, pc, guesses_branch, prediction} in strict FIFO order, so that fetch
// bursts and decode stalls do not have to line up. The head entry drives the
// decoder directly. i_flush (decoder inconsistency OR backend mispredict,
// combined outside this block) discards every queued entry.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN):
//   When defined and the queue is empty, an incoming enqueue appears on
//   o_deq_* in the same cycle. If decode takes it that cycle it is never
//   written. When undefined, o_deq_* depend on registered state only and the
//   minimum fetch-to-decode latency is one cycle.
//
// Parameters:
//   DEPTH  number of entries (power of 2, >= 2)
//   PTR_W  slot index width, derived from DEPTH
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_flush                  discard all entries and any same-cycle enqueue
//   i_enq_*                  fetch side: valid, instr, pc, guesses_branch,
//                            prediction
//   o_enq_ready              queue can accept this cycle (= not full)
//   o_deq_*                  decode side: head valid and head fields
//                            (all zero whenever o_deq_valid is 0)
//   i_deq_ready              decode consumes the head this cycle
//   o_count                  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module fetch_queue #(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_enq_valid,
  input  logic [31:0]            i_enq_instr,
  input  logic [`ADDR_WIDTH-1:0] i_enq_pc,
  input  logic                   i_enq_guesses_branch,
  input  logic [`ADDR_WIDTH-1:0] i_enq_prediction,
  output logic                   o_enq_ready,
  output logic                   o_deq_valid,
  output logic [31:0]            o_deq_instr,
  output logic [`ADDR_WIDTH-1:0] o_deq_pc,
  output logic                   o_deq_guesses_branch,
  output logic [`ADDR_WIDTH-1:0] o_deq_prediction,
  input  logic                   i_deq_ready,
  output logic [PTR_W:0]         o_count
);

  typedef struct packed {
    logic [31:0]            instr;
    logic [`ADDR_WIDTH-1:0] pc;
    logic                   guesses_branch;
    logic [`ADDR_WIDTH-1:0] prediction;
  } entry_t;

  localparam logic [PTR_W:0] PTR_ONE = 1;

  entry_t         mem [DEPTH];
  logic [PTR_W:0] head_ptr;
  logic [PTR_W:0] tail_ptr;

  entry_t enq_entry;
  entry_t head_entry;
  logic   empty;
  logic   full;
  logic   deq_valid;
  logic   enq_fire;
  logic   deq_fire;
  logic   bypass_take;
  logic   do_write;
  logic   do_pop;

  assign enq_entry = '{instr:          i_enq_instr,
                       pc:             i_enq_pc,
                       guesses_branch: i_enq_guesses_branch,
                       prediction:     i_enq_prediction};

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign empty = (head_ptr == tail_ptr);
  assign full  = (head_ptr[PTR_W-1:0] == tail_ptr[PTR_W-1:0]) &&
                 (head_ptr[PTR_W] != tail_ptr[PTR_W]);

  // Ready comes from registered state only: a full queue rejects even when
  // the head is being consumed in the same cycle.
  assign o_enq_ready = ~full;
  assign o_count     = tail_ptr - head_ptr;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    head_entry = mem[head_ptr[PTR_W-1:0]];
    deq_valid  = ~empty;
`ifdef FETCH_QUEUE_BYPASS_EN
    if (empty && i_enq_valid && !i_flush) begin
      head_entry = enq_entry;
      deq_valid  = 1'b1;
    end
`endif
  end

  // Data outputs are forced to zero when there is no valid head, so stale or
  // uninitialised slot contents never reach the decoder.
  assign o_deq_valid          = deq_valid;
  assign o_deq_instr          = deq_valid ? head_entry.instr          : '0;
  assign o_deq_pc             = deq_valid ? head_entry.pc             : '0;
  assign o_deq_guesses_branch = deq_valid ? head_entry.guesses_branch : 1'b0;
  assign o_deq_prediction     = deq_valid ? head_entry.prediction     : '0;

  assign enq_fire = i_enq_valid & o_enq_ready & ~i_flush;
  assign deq_fire = deq_valid & i_deq_ready & ~i_flush;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Bypassed entry consumed in its arrival cycle: nothing is stored.
  assign bypass_take = empty & enq_fire & deq_fire;
`else
  assign bypass_take = 1'b0;
`endif

  assign do_write = enq_fire & ~bypass_take;
  assign do_pop   = deq_fire & ~bypass_take;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
    end else if (i_flush) begin
      // Flush empties the queue by catching head up to tail; pointers keep
      // running rather than returning to zero.
      head_ptr <= tail_ptr;
    end else begin
      if (do_write) tail_ptr <= tail_ptr + PTR_ONE;
      if (do_pop)   head_ptr <= head_ptr + PTR_ONE;
    end
  end

  // NOTE: the storage array has no reset; slots are only read once the
  // pointers mark them valid, and outputs are masked otherwise.
  always_ff @(posedge clk) begin
    if (do_write) mem[tail_ptr[PTR_W-1:0]] <= enq_entry;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue. A queue-based reference model holds the
// expected contents; every cycle the DUT outputs are compared against it just
// before the clock edge, then the model is advanced with the same inputs.
// Directed sequences are followed by randomized traffic.
// -----------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AW    = `ADDR_WIDTH;

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic          gb;
    logic [AW-1:0] pred;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_flush;
  logic          i_enq_valid;
  logic [31:0]   i_enq_instr;
  logic [AW-1:0] i_enq_pc;
  logic          i_enq_guesses_branch;
  logic [AW-1:0] i_enq_prediction;
  logic          o_enq_ready;
  logic          o_deq_valid;
  logic [31:0]   o_deq_instr;
  logic [AW-1:0] o_deq_pc;
  logic          o_deq_guesses_branch;
  logic [AW-1:0] o_deq_prediction;
  logic          i_deq_ready;
  logic [PTR_W:0] o_count;

  int checks = 0;
  int errors = 0;

  ent_t model_q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_flush              (i_flush),
    .i_enq_valid          (i_enq_valid),
    .i_enq_instr          (i_enq_instr),
    .i_enq_pc             (i_enq_pc),
    .i_enq_guesses_branch (i_enq_guesses_branch),
    .i_enq_prediction     (i_enq_prediction),
    .o_enq_ready          (o_enq_ready),
    .o_deq_valid          (o_deq_valid),
    .o_deq_instr          (o_deq_instr),
    .o_deq_pc             (o_deq_pc),
    .o_deq_guesses_branch (o_deq_guesses_branch),
    .o_deq_prediction     (o_deq_prediction),
    .i_deq_ready          (i_deq_ready),
    .o_count              (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model shortly
  // before the rising edge, then advance the model as the edge would.
  task automatic step(input logic flush, input logic ev, input logic [31:0] instr,
                      input logic [AW-1:0] pc, input logic gb,
                      input logic [AW-1:0] pred, input logic dr);
    int   n;
    logic e_ready, e_valid, bypass;
    ent_t head;
    i_flush              = flush;
    i_enq_valid          = ev;
    i_enq_instr          = instr;
    i_enq_pc             = pc;
    i_enq_guesses_branch = gb;
    i_enq_prediction     = pred;
    i_deq_ready          = dr;
    @(negedge clk);
    n       = model_q.size();
    e_ready = (n < DEPTH);
    e_valid = (n > 0);
    bypass  = 1'b0;
    head    = '{instr: '0, pc: '0, gb: 1'b0, pred: '0};
    if (n > 0) head = model_q[0];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (n == 0 && ev && !flush) begin
      bypass  = 1'b1;
      e_valid = 1'b1;
      head    = '{instr: instr, pc: pc, gb: gb, pred: pred};
    end
`endif
    check("count",     64'(o_count),              64'(n));
    check("enq_ready", 64'(o_enq_ready),          64'(e_ready));
    check("deq_valid", 64'(o_deq_valid),          64'(e_valid));
    check("deq_instr", 64'(o_deq_instr),          64'(head.instr));
    check("deq_pc",    64'(o_deq_pc),             64'(head.pc));
    check("deq_gb",    64'(o_deq_guesses_branch), 64'(head.gb));
    check("deq_pred",  64'(o_deq_prediction),     64'(head.pred));
    @(posedge clk);
    if (flush) begin
      model_q.delete();
    end else if (bypass && dr) begin
      // consumed in flight, nothing stored
    end else begin
      if (e_valid && dr) void'(model_q.pop_front());
      if (ev && e_ready) model_q.push_back('{instr: instr, pc: pc, gb: gb, pred: pred});
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_flush = 1'b0; i_enq_valid = 1'b0; i_deq_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
  endtask

  task automatic enq(input logic [AW-1:0] pc, input logic dr);
    step(1'b0, 1'b1, 32'h0050_0093 + 32'(pc), pc, pc[2], pc + AW'(32'h10), dr);
  endtask

  task automatic idle(input logic dr);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, dr);
  endtask

  initial begin
    rst = 1'b1;
    i_flush = 1'b0; i_enq_valid = 1'b0; i_enq_instr = '0; i_enq_pc = '0;
    i_enq_guesses_branch = 1'b0; i_enq_prediction = '0; i_deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_count", 64'(o_count),     64'd0);
    check("rst_valid", 64'(o_deq_valid), 64'd0);
    check("rst_ready", 64'(o_enq_ready), 64'd1);
    check("rst_pc",    64'(o_deq_pc),    64'd0);
    @(posedge clk); #1;

    // Three entries held, then drained in order.
    step(1'b0, 1'b1, 32'h0050_0093, AW'(32'h100), 1'b0, AW'(32'h104), 1'b0);
    enq(AW'(32'h104), 1'b0);
    enq(AW'(32'h108), 1'b0);
    repeat (4) idle(1'b1);

    // Fill, reject a 9th alongside a dequeue, accept it next cycle.
    for (int i = 0; i < DEPTH; i++) enq(AW'(32'h1000 + 4 * i), 1'b0);
    enq(AW'(32'h1020), 1'b1);
    enq(AW'(32'h1020), 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

    // Continuous streaming across two wraps.
    for (int i = 0; i < 20; i++) enq(AW'(4 * i), 1'b1);
    repeat (2) idle(1'b1);

    // Flush with a same-cycle enqueue and dequeue.
    for (int i = 0; i < 5; i++) enq(AW'(32'h180 + 4 * i), 1'b0);
    step(1'b1, 1'b1, 32'h1234_5678, AW'(32'h200), 1'b0, AW'(32'h204), 1'b1);
    idle(1'b0);
    enq(AW'(32'h300), 1'b0);
    repeat (2) idle(1'b1);

    // Reset mid-stream discards a predicted-branch entry.
    step(1'b0, 1'b1, 32'h0000_006f, AW'(32'h40), 1'b1, AW'(32'h80), 1'b0);
    enq(AW'(32'h44), 1'b0);
    do_reset();
    idle(1'b0);
    idle(1'b1);

    // Same-cycle bypass case (or one-cycle latency when bypass is absent).
    enq(AW'(32'h500), 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 29) == 0, 1'($urandom_range(0, 3) != 0), $urandom,
             AW'($urandom), 1'($urandom), AW'($urandom),
             1'($urandom_range(0, 2) != 0));
      end
    end
    repeat (DEPTH + 1) idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
